// File: rtl/oscilo_pkg.sv
// oscilo_pkg: shared constants and FSM state types for the oscilloscope command/stream modules
package oscilo_pkg;

    // Frame start byte for every block streamed to the host
    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    // Command and acknowledge bytes understood by the receive-side modules
    localparam logic [7:0] CMD_ARM   = 8'h01;
    localparam logic [7:0] CMD_TRIG  = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    // Byte-streaming FSM of the sample sender
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_FETCH,
        ST_SEND,
`ifdef SAMPLE_SENDER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_DONE
    } stream_state_e;

    // UART handoff micro-sequence shared by transmit-side responders
    typedef enum logic [1:0] {
        BC_IDLE,
        BC_WAIT_HI,
        BC_WAIT_LO
    } byte_state_e;

endpackage

// File: rtl/tx_byte_ctrl.sv
// tx_byte_ctrl: hands one byte to the UART TX and reports when the UART has finished it
module tx_byte_ctrl
    import oscilo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] byte_in,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       sent
);

    byte_state_e state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;

    // Start only from idle with the UART free, then track the busy rise and fall
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        case (state_q)
            BC_IDLE: begin
                if (send && !tx_busy) begin
                    tx_data_d  = byte_in;
                    tx_start_d = 1'b1;
                    state_d    = BC_WAIT_HI;
                end
            end
            BC_WAIT_HI: state_d = tx_busy ? BC_WAIT_LO : BC_WAIT_HI;
            BC_WAIT_LO: state_d = tx_busy ? BC_WAIT_LO : BC_IDLE;
            default:    state_d = BC_IDLE;
        endcase
    end

    // The byte is complete the cycle busy is seen low again after its rise
    assign sent     = (state_q == BC_WAIT_LO) && !tx_busy;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;

    // State and registered UART outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BC_IDLE;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

endmodule

// File: rtl/sample_sender.sv
// sample_sender: streams a sample block as A5, len16, samples[, xor checksum when SAMPLE_SENDER_CHECKSUM_EN]
module sample_sender
    import oscilo_pkg::*;
#(
    parameter int         WIDTH  = 8,
    parameter int         ADDR_W = 10,
    parameter logic [7:0] HEADER = FRAME_HEADER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              activate,
    output logic              done,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

    localparam int BYTES = (WIDTH + 7) / 8;
    localparam int SW    = BYTES * 8;
    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
`ifdef SAMPLE_SENDER_CHECKSUM_EN
    localparam stream_state_e END_ST = ST_CHK;
`else
    localparam stream_state_e END_ST = ST_DONE;
`endif

    stream_state_e     state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SW-1:0]     shift_q, shift_d;
    logic [1:0]        bidx_q, bidx_d;
    logic              wait_q, wait_d;
    logic              done_q, done_d;
`ifdef SAMPLE_SENDER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif
    logic [15:0]       len16;
    logic [7:0]        tx_byte;
    logic              send;
    logic              sent;

    assign len16 = 16'(len_q);

    // Frame sequencing: header, length, per-sample fetch and byte split, optional checksum
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        bidx_d  = bidx_q;
        wait_d  = wait_q;
`ifdef SAMPLE_SENDER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        send    = 1'b0;
        tx_byte = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (activate) begin
                    len_d   = (length > DEPTH_L) ? DEPTH_L : length;
                    cnt_d   = '0;
                    addr_d  = '0;
                    bidx_d  = '0;
                    wait_d  = 1'b0;
`ifdef SAMPLE_SENDER_CHECKSUM_EN
                    chk_d   = 8'h00;
`endif
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                send    = 1'b1;
                tx_byte = HEADER;
                state_d = sent ? ST_LEN_HI : ST_HDR;
            end
            ST_LEN_HI: begin
                send    = 1'b1;
                tx_byte = len16[15:8];
                state_d = sent ? ST_LEN_LO : ST_LEN_HI;
            end
            ST_LEN_LO: begin
                send    = 1'b1;
                tx_byte = len16[7:0];
                if (sent)
                    state_d = (len_q == '0) ? END_ST : ST_FETCH;
            end
            ST_FETCH: begin
                // First cycle lets the synchronous buffer read settle, second captures it
                wait_d = 1'b1;
                if (wait_q) begin
                    shift_d = SW'(mem_data);
                    wait_d  = 1'b0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                send    = 1'b1;
                tx_byte = shift_q[SW-1 -: 8];
                if (sent) begin
                    if (bidx_q == 2'(BYTES - 1)) begin
                        bidx_d  = '0;
                        cnt_d   = cnt_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                        state_d = (cnt_d == len_q) ? END_ST : ST_FETCH;
                    end else begin
                        bidx_d  = bidx_q + 2'd1;
                        shift_d = shift_q << 8;
                    end
                end
            end
`ifdef SAMPLE_SENDER_CHECKSUM_EN
            ST_CHK: begin
                send    = 1'b1;
                tx_byte = chk_q;
                state_d = sent ? ST_DONE : ST_CHK;
            end
`endif
            ST_DONE: state_d = activate ? ST_DONE : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef SAMPLE_SENDER_CHECKSUM_EN
        // Everything after the header feeds the checksum
        if (sent && (state_q == ST_LEN_HI || state_q == ST_LEN_LO || state_q == ST_SEND))
            chk_d = chk_q ^ tx_byte;
`endif
        done_d = (state_d == ST_DONE);
    end

    tx_byte_ctrl u_tx (
        .clk      (clk),
        .rst      (rst),
        .send     (send),
        .byte_in  (tx_byte),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .sent     (sent)
    );

    assign done     = done_q;
    assign mem_addr = addr_q;

    // Frame state registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            bidx_q  <= '0;
            wait_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SAMPLE_SENDER_CHECKSUM_EN
            chk_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            bidx_q  <= bidx_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
`ifdef SAMPLE_SENDER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

endmodule
